mips_multicycle_top: RTL



---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_control.sv | 60 ++++++
 rtl/mips_multicycle_top.sv | 100 ++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes, ALU encodings and control word for the multi-cycle MIPS core
package mc_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;
  typedef enum logic [2:0] {PC_HOLD, PC_INC, PC_BR, PC_JMP, PC_REG} pc_sel_t;
  typedef struct packed {
    logic    ir_we;
    logic    ab_we;
    logic    alu_we;
    logic    mdr_we;
    logic    dmem_we;
    logic    link_we;
    logic    rf_we;
    logic    rf_dst_rd;
    logic    mem_to_reg;
    logic    use_imm;
    logic    retire;
    pc_sel_t pc_sel;
    alu_op_t alu_op;
  } ctrl_t;
  function automatic alu_op_t funct_to_alu(input logic [5:0] f);
    return f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND : f == F_OR ? ALU_OR :
           f == F_SLT ? ALU_SLT : f == F_SLL ? ALU_SLL : f == F_SRL ? ALU_SRL : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_control.sv
// mc_control: instruction-step FSM and per-state control decode
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       eq,
  output state_t     state,
  output ctrl_t      ctrl
);
  state_t next;
  logic is_r, r_ok, is_jr, ld, st, supported;
  always_comb begin
    is_r = op == OP_R;
    r_ok = is_r && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR});
    is_jr = is_r && funct == F_JR;
    ld = op == OP_LW;
    st = op == OP_SW;
    supported = r_ok || (op inside {OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
    next = state;
    ctrl = '0;
    ctrl.alu_op = is_r ? funct_to_alu(funct) : ALU_ADD;
    ctrl.use_imm = !is_r;
    ctrl.rf_dst_rd = is_r;
    ctrl.mem_to_reg = ld;
    case (state)
      FETCH: begin
        ctrl.ir_we = 1'b1;
        ctrl.pc_sel = PC_INC;
        next = DECODE;
      end
      DECODE: begin
        ctrl.ab_we = 1'b1;
        next = op == OP_HALT ? HALT : supported ? EXEC : FETCH;
      end
      EXEC: begin
        ctrl.alu_we = 1'b1;
        ctrl.link_we = op == OP_JAL;
        ctrl.pc_sel = (op == OP_BEQ && eq) ? PC_BR : (op == OP_J || op == OP_JAL) ? PC_JMP :
                      is_jr ? PC_REG : PC_HOLD;
        next = (ld || st) ? MEM : ((is_r && !is_jr) || op == OP_ADDI) ? WB : FETCH;
      end
      MEM: begin
        ctrl.dmem_we = st;
        ctrl.mdr_we = ld;
        next = ld ? WB : FETCH;
      end
      WB: begin
        ctrl.rf_we = 1'b1;
        next = FETCH;
      end
      default: next = HALT;
    endcase
    ctrl.retire = (state inside {EXEC, MEM, WB}) && next == FETCH;
  end
  always_ff @(posedge clk)
    state <= rst ? FETCH : next;
endmodule

// File: rtl/mips_multicycle_top.sv
// mips_multicycle_top: multi-cycle MIPS core with loader/readback memories.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mips_multicycle_top
  import mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IMEM_AW  = 10,
  parameter int DMEM_AW  = 10,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic [IMEM_AW-1:0] instr_addr,
  input  logic               ins_we,
  input  logic [XLEN-1:0]    data,
  input  logic [DMEM_AW-1:0] data_addr,
  input  logic               data_we,
  output logic [XLEN-1:0]    processor_out,
  output logic               done
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retired_cnt
`endif
);
  logic [31:0]     imem [2**IMEM_AW];
  logic [XLEN-1:0] dmem [2**DMEM_AW];
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] pc, a, b, alu_out, mdr, imm, alu_b, alu_y, wb_val;
  logic [31:0]     ir;
  logic [4:0]      wb_dst;
  state_t          state;
  ctrl_t           ctrl;
  mc_control u_ctrl (
    .clk  (clk),
    .rst  (rst),
    .op   (ir[31:26]),
    .funct(ir[5:0]),
    .eq   (a == b),
    .state(state),
    .ctrl (ctrl)
  );
  always_comb begin
    imm = {{(XLEN-16){ir[15]}}, ir[15:0]};
    alu_b = ctrl.use_imm ? imm : b;
    alu_y = ctrl.alu_op == ALU_SUB ? a - alu_b :
            ctrl.alu_op == ALU_AND ? a & alu_b :
            ctrl.alu_op == ALU_OR  ? a | alu_b :
            ctrl.alu_op == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(alu_b)} :
            ctrl.alu_op == ALU_SLL ? alu_b << ir[10:6] :
            ctrl.alu_op == ALU_SRL ? alu_b >> ir[10:6] : a + alu_b;
    wb_dst = ctrl.rf_dst_rd ? ir[15:11] : ir[20:16];
    wb_val = ctrl.mem_to_reg ? mdr : alu_out;
  end
  assign done = state == HALT;
  assign processor_out = dmem[done ? data_addr : alu_out[DMEM_AW-1:0]];
  // The loader owns both memories during reset; the core store is masked then.
  always_ff @(posedge clk) begin
    if (rst && ins_we) imem[instr_addr] <= instr;
    if (rst ? data_we : ctrl.dmem_we)
      dmem[rst ? data_addr : alu_out[DMEM_AW-1:0]] <= rst ? data : b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= XLEN'(RESET_PC);
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      rf <= '{default: '0};
    end else begin
      if (ctrl.ir_we) ir <= imem[pc[IMEM_AW-1:0]];
      pc <= ctrl.pc_sel == PC_INC ? pc + XLEN'(1) :
            ctrl.pc_sel == PC_BR  ? pc + imm :
            ctrl.pc_sel == PC_JMP ? {pc[XLEN-1:26], ir[25:0]} :
            ctrl.pc_sel == PC_REG ? a : pc;
      if (ctrl.ab_we) begin
        a <= rf[ir[25:21]];
        b <= rf[ir[20:16]];
      end
      if (ctrl.alu_we) alu_out <= alu_y;
      if (ctrl.mdr_we) mdr <= dmem[alu_out[DMEM_AW-1:0]];
      if (ctrl.link_we) rf[31] <= pc;
      if (ctrl.rf_we && wb_dst != 5'd0) rf[wb_dst] <= wb_val;
    end
  end
`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != HALT && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
      if (ctrl.retire && retired_cnt != '1) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif
endmodule
